// File: rtl/mem_if_pkg.sv
// Shared encodings for the IF/data memory-port arbitration slice.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mem_if_pkg;

    // Access size as driven on the memory port.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Owner tag stored per outstanding transaction.
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Which requester currently holds the memory port mid-handshake.
    typedef enum logic [1:0] {
        LOCK_NONE = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } lock_e;

    // True for the three size encodings the memory port understands.
    function automatic logic size_is_legal(input logic [1:0] sz);
        return (sz == SZ_B) || (sz == SZ_H) || (sz == SZ_W);
    endfunction

endpackage

// File: rtl/owner_fifo.sv
// In-order FIFO of 1-bit owner tags for accepted-but-unanswered transactions.
// Latency: push/pop take effect at the next clock; head_o is the oldest tag.
// Backpressure: full_o/empty_o flags; a push when full or a pop when empty is ignored.
module owner_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic push_i,
    input  logic push_dat_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Next-state for storage, pointers (wrap naturally, DEPTH is a power of 2) and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat_i;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between inst fetch and data access; routes responses back in order.
// Latency: zero-cycle combinational request mux and response pass-through.
// Backpressure: stalls both requesters when OT_DEPTH transactions are outstanding; holds a stalled requester locked.
module sram_req_arbiter
    import mem_if_pkg::*;
#(
    parameter int OT_DEPTH   = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata,
    output logic        err_spurious
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    lock_e         lock_q, lock_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          err_q, err_d;

    logic sel_inst, sel_data;
    logic accept, pop;
    logic fifo_full, fifo_empty, fifo_head;

    owner_fifo #(
        .DEPTH (OT_DEPTH)
    ) u_owner_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push_i     (accept),
        .push_dat_i (sel_data ? OWN_D : OWN_I),
        .pop_i      (pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_o     (fifo_head)
    );

    // Lock, starvation counter and spurious-response flag registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_q   <= LOCK_NONE;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            lock_q   <= lock_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    // Requester selection, request mux and next-state for lock/starvation/error.
    always_comb begin
        sel_inst = 1'b0;
        sel_data = 1'b0;
        lock_d   = lock_q;
        starve_d = starve_q;
        err_d    = err_q | (s_data_ok & fifo_empty);

        // A full owner FIFO blocks everyone; a locked requester keeps the port until accepted.
        if (!fifo_full) begin
            case (lock_q)
                LOCK_INST: sel_inst = 1'b1;
                LOCK_DATA: sel_data = 1'b1;
                default: begin
                    if (d_req && !(i_req && (starve_q == STARVE_TOP))) begin
                        sel_data = 1'b1;
                    end else if (i_req) begin
                        sel_inst = 1'b1;
                    end
                end
            endcase
        end

        s_req   = (sel_data & d_req) | (sel_inst & i_req);
        s_wr    = sel_data ? d_wr    : 1'b0;
        s_size  = sel_data ? d_size  : SZ_W;
        s_addr  = sel_data ? d_addr  : i_addr;
        s_wstrb = sel_data ? d_wstrb : 4'h0;
        s_wdata = sel_data ? d_wdata : 32'h0;

        accept = s_req & s_addr_ok;

        // Hold the port for a stalled requester; any s_addr_ok releases it.
        if (accept || s_addr_ok) begin
            lock_d = LOCK_NONE;
        end else if (s_req) begin
            lock_d = sel_data ? LOCK_DATA : LOCK_INST;
        end

        if (accept && sel_inst) begin
            starve_d = '0;
        end else if (accept && sel_data && i_req && (starve_q != STARVE_TOP)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    assign i_addr_ok = accept & sel_inst;
    assign d_addr_ok = accept & sel_data;

    // Responses return in issue order, so the FIFO head names the owner.
    assign pop       = s_data_ok & ~fifo_empty;
    assign i_data_ok = pop & (fifo_head == OWN_I);
    assign d_data_ok = pop & (fifo_head == OWN_D);
    assign i_rdata   = s_rdata;
    assign d_rdata   = s_rdata;

    assign err_spurious = err_q;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for the shared memory-port arbiter: directed scenarios plus randomized traffic.
// Latency: outputs are sampled mid-cycle and on the falling edge.
// Backpressure: requesters hold requests until their addr_ok is seen.
module tb_sram_req_arbiter;

    localparam int OT_DEPTH   = 4;
    localparam int STARVE_MAX = 3;

    logic        clk;
    logic        resetn;
    logic        i_req, d_req, d_wr, s_addr_ok, s_data_ok;
    logic [31:0] i_addr, d_addr, d_wdata, s_rdata;
    logic [1:0]  d_size;
    logic [3:0]  d_wstrb;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [31:0] i_rdata, d_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        err_spurious;

    int checks   = 0;
    int failures = 0;

    sram_req_arbiter #(
        .OT_DEPTH   (OT_DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_addr_ok    (i_addr_ok),
        .i_data_ok    (i_data_ok),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_wr         (d_wr),
        .d_size       (d_size),
        .d_addr       (d_addr),
        .d_wstrb      (d_wstrb),
        .d_wdata      (d_wdata),
        .d_addr_ok    (d_addr_ok),
        .d_data_ok    (d_data_ok),
        .d_rdata      (d_rdata),
        .s_req        (s_req),
        .s_wr         (s_wr),
        .s_size       (s_size),
        .s_addr       (s_addr),
        .s_wstrb      (s_wstrb),
        .s_wdata      (s_wdata),
        .s_addr_ok    (s_addr_ok),
        .s_data_ok    (s_data_ok),
        .s_rdata      (s_rdata),
        .err_spurious (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- Behavioural model ----------------
    // Outstanding owners in issue order (1 = data), the requester caught mid-handshake
    // (0 none, 1 inst, 2 data), consecutive data wins while inst waited, sticky error.
    bit mq[$];
    int m_held   = 0;
    int m_starve = 0;
    bit m_err    = 1'b0;

    int e_sel;
    bit e_full, e_sreq, e_acc, e_pop;

    always @(negedge clk) begin
        e_full = (mq.size() == OT_DEPTH);
        e_sel  = 0;
        if (!e_full) begin
            if (m_held != 0)           e_sel = m_held;
            else if (d_req && i_req)   e_sel = (m_starve == STARVE_MAX) ? 1 : 2;
            else if (d_req)            e_sel = 2;
            else if (i_req)            e_sel = 1;
        end
        e_sreq = (e_sel == 2) ? d_req : (e_sel == 1) ? i_req : 1'b0;
        e_acc  = e_sreq && s_addr_ok;
        e_pop  = s_data_ok && (mq.size() > 0);

        chk("s_req", {31'd0, s_req}, {31'd0, e_sreq});
        if (e_sreq) begin
            chk("s_wr",    {31'd0, s_wr},    (e_sel == 2) ? {31'd0, d_wr}    : 32'd0);
            chk("s_size",  {30'd0, s_size},  (e_sel == 2) ? {30'd0, d_size}  : 32'd2);
            chk("s_addr",  s_addr,           (e_sel == 2) ? d_addr           : i_addr);
            chk("s_wstrb", {28'd0, s_wstrb}, (e_sel == 2) ? {28'd0, d_wstrb} : 32'd0);
            chk("s_wdata", s_wdata,          (e_sel == 2) ? d_wdata          : 32'd0);
        end
        chk("i_addr_ok", {31'd0, i_addr_ok}, {31'd0, e_acc && (e_sel == 1)});
        chk("d_addr_ok", {31'd0, d_addr_ok}, {31'd0, e_acc && (e_sel == 2)});
        chk("i_data_ok", {31'd0, i_data_ok}, {31'd0, e_pop && (mq[0] == 1'b0)});
        chk("d_data_ok", {31'd0, d_data_ok}, {31'd0, e_pop && (mq[0] == 1'b1)});
        chk("i_rdata", i_rdata, s_rdata);
        chk("d_rdata", d_rdata, s_rdata);
        chk("err_spurious", {31'd0, err_spurious}, {31'd0, m_err});

        // Advance the model to the state after the coming rising edge.
        if (!resetn) begin
            mq.delete();
            m_held   = 0;
            m_starve = 0;
            m_err    = 1'b0;
        end else begin
            if (s_data_ok && mq.size() == 0) m_err = 1'b1;
            if (e_pop) void'(mq.pop_front());
            if (e_acc) begin
                mq.push_back(e_sel == 2);
                m_held = 0;
                if (e_sel == 1)             m_starve = 0;
                else if (i_req && m_starve < STARVE_MAX) m_starve++;
            end else if (e_sreq) begin
                m_held = e_sel;
            end else if (s_addr_ok) begin
                m_held = 0;
            end
        end
    end

    // ---------------- Stimulus ----------------
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #2;
    endtask

    task automatic idle();
        i_req     = 1'b0;
        d_req     = 1'b0;
        s_addr_ok = 1'b0;
        s_data_ok = 1'b0;
    endtask

    string grants;
    string exp_grants;
    bit    i_acc, d_acc;

    initial begin
        resetn = 1'b0;
        idle();
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; s_rdata = 32'h0;
        d_wr = 1'b0; d_size = 2'd0; d_wstrb = 4'h0;
        nxt(); nxt();
        mid();
        chk("rst_s_req", {31'd0, s_req}, 32'd0);
        chk("rst_i_addr_ok", {31'd0, i_addr_ok}, 32'd0);
        chk("rst_err", {31'd0, err_spurious}, 32'd0);
        resetn = 1'b1;
        nxt();

        // Single instruction read.
        i_req = 1'b1; i_addr = 32'h1c000000; s_addr_ok = 1'b1;
        mid();
        chk("t1_s_req", {31'd0, s_req}, 32'd1);
        chk("t1_s_addr", s_addr, 32'h1c000000);
        chk("t1_i_addr_ok", {31'd0, i_addr_ok}, 32'd1);
        nxt();
        idle();
        nxt();
        s_data_ok = 1'b1; s_rdata = 32'h02800c0c;
        mid();
        chk("t1_i_data_ok", {31'd0, i_data_ok}, 32'd1);
        chk("t1_i_rdata", i_rdata, 32'h02800c0c);
        chk("t1_d_data_ok", {31'd0, d_data_ok}, 32'd0);
        nxt();
        idle();

        // Conflict and starvation: both requesting, memory always ready.
        grants = "";
        exp_grants = "DDDIDDDIDDD";
        d_wr = 1'b1; d_size = 2'd1; d_addr = 32'h2000; d_wstrb = 4'hf; d_wdata = 32'h5;
        i_addr = 32'h1c000004;
        for (int n = 0; n < 11; n++) begin
            i_req = 1'b1; d_req = 1'b1; s_addr_ok = 1'b1; s_data_ok = (n > 0);
            mid();
            if (d_addr_ok)      grants = {grants, "D"};
            else if (i_addr_ok) grants = {grants, "I"};
            else                grants = {grants, "-"};
            chk("t2_s_wr", {31'd0, s_wr}, d_addr_ok ? 32'd1 : 32'd0);
            chk("t2_s_size", {30'd0, s_size}, d_addr_ok ? 32'd1 : 32'd2);
            nxt();
        end
        checks++;
        if (grants != exp_grants) begin
            failures++;
            $display("FAIL t2_grant_order actual=%s expected=%s", grants, exp_grants);
        end
        idle();
        s_data_ok = 1'b1;
        nxt();
        idle();
        mid();
        chk("model_starve_sat", m_starve, 32'd3);
        chk("model_cnt_empty", mq.size(), 32'd0);
        nxt();

        // Lock: a stalled store keeps the port although inst would win on starvation.
        d_req = 1'b1; d_wr = 1'b1; d_size = 2'd1; d_addr = 32'h1000; d_wstrb = 4'h3;
        d_wdata = 32'hABCD1234;
        i_addr = 32'h1c000040;
        for (int n = 0; n < 4; n++) begin
            i_req = (n > 0); s_addr_ok = (n == 3);
            mid();
            chk("t3_s_req", {31'd0, s_req}, 32'd1);
            chk("t3_s_addr", s_addr, 32'h1000);
            chk("t3_s_wstrb", {28'd0, s_wstrb}, 32'h3);
            chk("t3_s_wdata", s_wdata, 32'hABCD1234);
            chk("t3_i_addr_ok", {31'd0, i_addr_ok}, 32'd0);
            chk("t3_d_addr_ok", {31'd0, d_addr_ok}, (n == 3) ? 32'd1 : 32'd0);
            nxt();
        end
        d_req = 1'b0; i_req = 1'b1; s_addr_ok = 1'b1;
        mid();
        chk("t3_i_addr_ok_after", {31'd0, i_addr_ok}, 32'd1);
        chk("t3_s_addr_after", s_addr, 32'h1c000040);
        nxt();
        idle(); s_data_ok = 1'b1; s_rdata = 32'haa;
        mid();
        chk("t3_d_data_ok", {31'd0, d_data_ok}, 32'd1);
        nxt();
        s_rdata = 32'hbb;
        mid();
        chk("t3_i_data_ok", {31'd0, i_data_ok}, 32'd1);
        nxt();
        idle();

        // Full: fill to OT_DEPTH, no bypass, then simultaneous accept+response at 3.
        i_req = 1'b1; i_addr = 32'h1c000080; s_addr_ok = 1'b1;
        for (int n = 0; n < 4; n++) begin
            mid();
            chk("t4_fill_i_addr_ok", {31'd0, i_addr_ok}, 32'd1);
            nxt();
        end
        mid();
        chk("t4_full_s_req", {31'd0, s_req}, 32'd0);
        chk("t4_full_i_addr_ok", {31'd0, i_addr_ok}, 32'd0);
        chk("model_cnt_full", mq.size(), 32'd4);
        nxt();
        s_data_ok = 1'b1;
        mid();
        chk("t4_nobypass_s_req", {31'd0, s_req}, 32'd0);
        chk("t4_pop_i_data_ok", {31'd0, i_data_ok}, 32'd1);
        nxt();
        s_data_ok = 1'b0;
        mid();
        chk("t4_reassert_s_req", {31'd0, s_req}, 32'd1);
        nxt();
        s_data_ok = 1'b1;
        mid();
        chk("t4_full2_s_req", {31'd0, s_req}, 32'd0);
        nxt();
        mid();
        chk("t4_both_i_addr_ok", {31'd0, i_addr_ok}, 32'd1);
        chk("t4_both_i_data_ok", {31'd0, i_data_ok}, 32'd1);
        nxt();
        s_data_ok = 1'b0; s_addr_ok = 1'b0;
        mid();
        chk("t4_cnt3_s_req", {31'd0, s_req}, 32'd1);
        chk("model_cnt_three", mq.size(), 32'd3);
        nxt();
        s_addr_ok = 1'b1;
        nxt();
        mid();
        chk("t4_refull_s_req", {31'd0, s_req}, 32'd0);
        nxt();
        idle();
        s_data_ok = 1'b1;
        repeat (4) nxt();
        idle();
        nxt();

        // Ordering: I, D, I then three responses.
        i_req = 1'b1; s_addr_ok = 1'b1;
        nxt();
        i_req = 1'b0; d_req = 1'b1; d_wr = 1'b0; d_size = 2'd2;
        nxt();
        d_req = 1'b0; i_req = 1'b1;
        nxt();
        idle(); s_data_ok = 1'b1; s_rdata = 32'h11;
        mid();
        chk("t5_r1_i_data_ok", {31'd0, i_data_ok}, 32'd1);
        chk("t5_r1_i_rdata", i_rdata, 32'h11);
        nxt();
        s_rdata = 32'h22;
        mid();
        chk("t5_r2_d_data_ok", {31'd0, d_data_ok}, 32'd1);
        chk("t5_r2_d_rdata", d_rdata, 32'h22);
        nxt();
        s_rdata = 32'h33;
        mid();
        chk("t5_r3_i_data_ok", {31'd0, i_data_ok}, 32'd1);
        chk("t5_r3_i_rdata", i_rdata, 32'h33);
        nxt();
        idle();

        // Spurious response, then reset with two outstanding.
        s_data_ok = 1'b1;
        mid();
        chk("t6_sp_i_data_ok", {31'd0, i_data_ok}, 32'd0);
        chk("t6_sp_d_data_ok", {31'd0, d_data_ok}, 32'd0);
        nxt();
        idle(); i_req = 1'b1; s_addr_ok = 1'b1;
        mid();
        chk("t6_err_set", {31'd0, err_spurious}, 32'd1);
        nxt();
        i_req = 1'b0; d_req = 1'b1;
        nxt();
        idle(); resetn = 1'b0;
        nxt();
        resetn = 1'b1; s_data_ok = 1'b1;
        mid();
        chk("t6_rst_err", {31'd0, err_spurious}, 32'd0);
        chk("t6_rst_i_data_ok", {31'd0, i_data_ok}, 32'd0);
        chk("t6_rst_d_data_ok", {31'd0, d_data_ok}, 32'd0);
        nxt();
        s_data_ok = 1'b0;
        mid();
        chk("t6_err_again", {31'd0, err_spurious}, 32'd1);
        nxt();

        // Randomized traffic; requesters hold a request until it is accepted.
        i_acc = 1'b0; d_acc = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            resetn = ($urandom_range(0, 399) != 0);
            if (!i_req || i_acc) begin
                i_req  = ($urandom_range(0, 2) == 0);
                i_addr = $urandom;
            end
            if (!d_req || d_acc) begin
                d_req   = ($urandom_range(0, 2) == 0);
                d_wr    = $urandom_range(0, 1);
                d_size  = 2'($urandom_range(0, 2));
                d_addr  = $urandom;
                d_wstrb = 4'($urandom);
                d_wdata = $urandom;
            end
            s_addr_ok = $urandom_range(0, 1);
            s_data_ok = (mq.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 99) == 0);
            s_rdata   = $urandom;
            mid();
            i_acc = i_addr_ok;
            d_acc = d_addr_ok;
            nxt();
        end
        resetn = 1'b1;
        idle();
        for (int n = 0; n < OT_DEPTH + 2; n++) begin
            s_data_ok = (mq.size() > 0);
            nxt();
        end
        idle();
        nxt();
        chk("drain_model_cnt", mq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
